// File: rtl/j1708_tx_scheduler.sv
// Shares one J1708 TX state machine among four host mailboxes: priority arbitration
// with round-robin tie-break, FIFO strobe routing, per-source ack/done/abort. Optional
// per-message watchdog enabled by defining J1708_SCHED_TIMEOUT_EN.
module j1708_tx_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_length,
  input  logic [11:0] req_priority,
  input  logic [3:0]  req_fifo_empty,
  output logic [3:0]  req_ack,
  output logic [3:0]  req_next_data,
  output logic [3:0]  req_done,
  output logic [3:0]  req_abort,
  output logic [7:0]  message_length,
  output logic [2:0]  message_priority,
  output logic        message_new,
  input  logic        message_length_read,
  output logic        fifo_data_empty,
  input  logic        message_next_data,
  input  logic        message_done,
  output logic        tx_enable,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam int NUM_SRC = 4;

`ifdef J1708_SCHED_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ARB, OFFER, XFER, DONE, ABORT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ARB, OFFER, XFER, DONE} state_t;
`endif

  state_t      state, state_n;
  logic [1:0]  rr_ptr;
  logic        run;
  logic [2:0]  prio_a [NUM_SRC];
  logic [7:0]  len_a  [NUM_SRC];
  logic        win_found;
  logic [1:0]  win_id, idx;
  logic [2:0]  win_prio;
  logic        routed;
  logic        expired;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_src
      assign prio_a[g] = req_priority[3*g +: 3];
      assign len_a[g]  = req_length[8*g +: 8];
      assign req_ack[g]       = (state == OFFER) && message_length_read && (grant_id == 2'(g));
      assign req_next_data[g] = routed && message_next_data && (grant_id == 2'(g));
      assign req_done[g]      = (state == DONE) && (grant_id == 2'(g));
`ifdef J1708_SCHED_TIMEOUT_EN
      assign req_abort[g]     = (state == ABORT) && (grant_id == 2'(g));
`else
      assign req_abort[g]     = 1'b0;
`endif
    end
  endgenerate

  // Search from the round-robin pointer; strict '<' keeps the earliest index on a tie.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_ptr;
    win_prio  = 3'd7;
    idx       = rr_ptr;
    for (int j = 0; j < NUM_SRC; j++) begin
      idx = rr_ptr + 2'(j);
      if (req_valid[idx] && (!win_found || prio_a[idx] < win_prio)) begin
        win_found = 1'b1;
        win_id    = idx;
        win_prio  = prio_a[idx];
      end
    end
  end

`ifdef J1708_SCHED_TIMEOUT_EN
  logic [31:0] wd_cnt;
  assign expired = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                wd_cnt <= '0;
    else if (state == ARB)                     wd_cnt <= '0;
    else if (state == OFFER || state == XFER)  wd_cnt <= wd_cnt + 32'd1;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (req_valid != 4'b0000) state_n = ARB;
      ARB:   state_n = win_found ? OFFER : IDLE;
      OFFER: begin
        if (message_length_read) state_n = XFER;
`ifdef J1708_SCHED_TIMEOUT_EN
        else if (expired)        state_n = ABORT;
`endif
      end
      XFER: begin
        if (message_done)        state_n = DONE;
`ifdef J1708_SCHED_TIMEOUT_EN
        else if (expired)        state_n = ABORT;
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      rr_ptr           <= 2'd0;
      grant_id         <= 2'd0;
      message_length   <= 8'd0;
      message_priority <= 3'd0;
      run              <= 1'b0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
      if (state == ARB && win_found) begin
        grant_id         <= win_id;
        message_length   <= len_a[win_id];
        message_priority <= prio_a[win_id];
      end
`ifdef J1708_SCHED_TIMEOUT_EN
      if (state == DONE || state == ABORT) rr_ptr <= grant_id + 2'd1;
`else
      if (state == DONE) rr_ptr <= grant_id + 2'd1;
`endif
    end
  end

  // run keeps tx_enable low while reset is held and for the first edge after release.
  assign routed          = (state == OFFER) || (state == XFER);
  assign fifo_data_empty = routed ? req_fifo_empty[grant_id] : 1'b1;
  assign message_new     = (state == OFFER);
  assign busy            = (state != IDLE);
`ifdef J1708_SCHED_TIMEOUT_EN
  assign tx_enable       = enable && run && (state != ABORT);
`else
  assign tx_enable       = enable && run;
`endif

endmodule

// File: tb/tb_j1708_tx_scheduler.sv
// Directed bench for j1708_tx_scheduler: arbitration vector table plus hand sequences
// for FIFO routing, enable drop, watchdog (when the macro is defined) and mid-message reset.
module tb_j1708_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_length = '0;
  logic [11:0] req_priority = '0;
  logic [3:0]  req_fifo_empty = 4'b1111;
  logic [3:0]  req_ack, req_next_data, req_done, req_abort;
  logic [7:0]  message_length;
  logic [2:0]  message_priority;
  logic        message_new;
  logic        message_length_read = 1'b0;
  logic        fifo_data_empty;
  logic        message_next_data = 1'b0;
  logic        message_done = 1'b0;
  logic        tx_enable, busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  j1708_tx_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_length(req_length), .req_priority(req_priority),
    .req_fifo_empty(req_fifo_empty), .req_ack(req_ack), .req_next_data(req_next_data),
    .req_done(req_done), .req_abort(req_abort), .message_length(message_length),
    .message_priority(message_priority), .message_new(message_new),
    .message_length_read(message_length_read), .fifo_data_empty(fifo_data_empty),
    .message_next_data(message_next_data), .message_done(message_done),
    .tx_enable(tx_enable), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] prio;
    logic [31:0] len;
    logic [1:0]  gid;
    logic [7:0]  elen;
    logic [2:0]  eprio;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0] oh;
    int fcnt;
    int n;

    // sources packed as {src3, src2, src1, src0}
    vecs[0] = '{4'b1001, {3'd1, 3'd0, 3'd0, 3'd6}, {8'd9, 8'd0, 8'd0, 8'd3}, 2'd3, 8'd9, 3'd1};
    vecs[1] = '{4'b0111, {3'd0, 3'd4, 3'd4, 3'd4}, {8'd0, 8'd12, 8'd11, 8'd10}, 2'd0, 8'd10, 3'd4};
    vecs[2] = '{4'b0111, {3'd0, 3'd4, 3'd4, 3'd4}, {8'd0, 8'd12, 8'd11, 8'd10}, 2'd1, 8'd11, 3'd4};
    vecs[3] = '{4'b0111, {3'd0, 3'd4, 3'd4, 3'd4}, {8'd0, 8'd12, 8'd11, 8'd10}, 2'd2, 8'd12, 3'd4};
    vecs[4] = '{4'b0111, {3'd0, 3'd4, 3'd4, 3'd4}, {8'd0, 8'd12, 8'd11, 8'd10}, 2'd0, 8'd10, 3'd4};
    vecs[5] = '{4'b1111, {3'd7, 3'd2, 3'd2, 3'd5}, {8'd40, 8'd31, 8'd21, 8'd50}, 2'd1, 8'd21, 3'd2};
    vecs[6] = '{4'b1111, {3'd7, 3'd2, 3'd2, 3'd5}, {8'd40, 8'd31, 8'd21, 8'd50}, 2'd2, 8'd31, 3'd2};

    // reset values
    #2;
    chk("rst_message_new", 32'(message_new), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_enable", 32'(tx_enable), 32'd0);
    chk("rst_fifo_data_empty", 32'(fifo_data_empty), 32'd1);
    chk("rst_outs", {14'd0, req_ack, req_next_data, req_done, req_abort, grant_id},
        32'd0);
    chk("rst_msg", {21'd0, message_length, message_priority}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("tx_enable_after_rst", 32'(tx_enable), 32'd1);

    // source 2 alone with a 5-byte FIFO
    req_valid = 4'b0100;
    req_length = {8'd0, 8'd5, 8'd0, 8'd0};
    req_priority = {3'd0, 3'd3, 3'd0, 3'd0};
    req_fifo_empty = 4'b1011;
    fcnt = 5;
    step();
    chk("a_arb_new", 32'(message_new), 32'd0);
    chk("a_arb_busy", 32'(busy), 32'd1);
    step();
    chk("a_new", 32'(message_new), 32'd1);
    chk("a_len", 32'(message_length), 32'd5);
    chk("a_prio", 32'(message_priority), 32'd3);
    chk("a_grant", 32'(grant_id), 32'd2);
    message_length_read = 1'b1;
    #1;
    chk("a_ack", 32'(req_ack), 32'b0100);
    step();
    message_length_read = 1'b0;
    #1;
    chk("a_ack_clear", 32'(req_ack), 32'd0);
    for (int i = 0; i < 5; i++) begin
      message_next_data = 1'b1;
      #1;
      chk("a_strobe", 32'(req_next_data), 32'b0100);
      chk("a_fifo_not_empty", 32'(fifo_data_empty), 32'd0);
      step();
      fcnt--;
      req_fifo_empty[2] = (fcnt == 0);
    end
    message_next_data = 1'b0;
    #1;
    chk("a_fifo_empty", 32'(fifo_data_empty), 32'd1);
    chk("a_no_strobe", 32'(req_next_data), 32'd0);
    message_done = 1'b1;
    step();
    message_done = 1'b0;
    req_valid = 4'b0000;
    chk("a_done", 32'(req_done), 32'b0100);
    step();
    chk("a_done_clear", 32'(req_done), 32'd0);
    chk("a_idle", 32'(busy), 32'd0);

    // arbitration table
    for (int k = 0; k < 7; k++) begin
      oh = 4'b0001 << vecs[k].gid;
      req_valid = vecs[k].valid;
      req_priority = vecs[k].prio;
      req_length = vecs[k].len;
      req_fifo_empty = 4'b0000;
      step();
      chk("v_arb_busy", 32'(busy), 32'd1);
      step();
      chk("v_new", 32'(message_new), 32'd1);
      chk("v_grant", 32'(grant_id), 32'(vecs[k].gid));
      chk("v_len", 32'(message_length), 32'(vecs[k].elen));
      chk("v_prio", 32'(message_priority), 32'(vecs[k].eprio));
      message_length_read = 1'b1;
      #1;
      chk("v_ack", 32'(req_ack), 32'(oh));
      step();
      message_length_read = 1'b0;
      message_next_data = 1'b1;
      #1;
      chk("v_strobe", 32'(req_next_data), 32'(oh));
      step();
      message_next_data = 1'b0;
      message_done = 1'b1;
      step();
      message_done = 1'b0;
      req_valid = 4'b0000;
      chk("v_done", 32'(req_done), 32'(oh));
      step();
      chk("v_idle", 32'(busy), 32'd0);
    end

    // enable dropped during XFER
    req_valid = 4'b0010;
    req_priority = '0;
    req_length = {8'd0, 8'd0, 8'd7, 8'd0};
    step();
    step();
    message_length_read = 1'b1;
    step();
    message_length_read = 1'b0;
    enable = 1'b0;
    message_next_data = 1'b1;
    #1;
    chk("en_tx_enable", 32'(tx_enable), 32'd0);
    step();
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_fifo_empty", 32'(fifo_data_empty), 32'd1);
    chk("en_no_strobe", 32'(req_next_data), 32'd0);
    chk("en_no_done", 32'(req_done), 32'd0);
    chk("en_grant_kept", 32'(grant_id), 32'd1);
    step();
    chk("en_no_done2", 32'(req_done), 32'd0);
    message_next_data = 1'b0;
    req_valid = 4'b0000;
    enable = 1'b1;
    step();

`ifdef J1708_SCHED_TIMEOUT_EN
    // watchdog: source 2 never completes, then source 1 is served
    req_valid = 4'b0110;
    req_priority = {3'd0, 3'd1, 3'd5, 3'd0};
    req_length = {8'd0, 8'd6, 8'd3, 8'd0};
    step();
    n = 0;
    while (n < 200 && req_abort == 4'b0000) begin
      step();
      n++;
    end
    // ABORT follows 100 OFFER/XFER cycles, i.e. the 101st edge after entering ARB
    chk("wd_latency", 32'(n), 32'd101);
    chk("wd_abort", 32'(req_abort), 32'b0100);
    chk("wd_tx_enable_low", 32'(tx_enable), 32'd0);
    req_valid = 4'b0010;
    step();
    chk("wd_abort_clear", 32'(req_abort), 32'd0);
    chk("wd_tx_enable_back", 32'(tx_enable), 32'd1);
    step();
    step();
    chk("wd_next_grant", 32'(grant_id), 32'd1);
    chk("wd_next_new", 32'(message_new), 32'd1);
    message_length_read = 1'b1;
    step();
    message_length_read = 1'b0;
    message_done = 1'b1;
    step();
    message_done = 1'b0;
    req_valid = 4'b0000;
    chk("wd_next_done", 32'(req_done), 32'b0010);
    step();
`endif

    // reset mid-XFER; the pointer is past 0 so only reset makes source 0 win the tie
    req_valid = 4'b1001;
    req_priority = {3'd2, 3'd0, 3'd0, 3'd2};
    req_length = {8'd8, 8'd0, 8'd0, 8'd4};
    step();
    step();
    chk("r_pre_grant", 32'(grant_id), 32'd3);
    message_length_read = 1'b1;
    step();
    message_length_read = 1'b0;
    message_next_data = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_new", 32'(message_new), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_tx_enable", 32'(tx_enable), 32'd0);
    chk("r_fifo_empty", 32'(fifo_data_empty), 32'd1);
    chk("r_outs", {14'd0, req_ack, req_next_data, req_done, req_abort, grant_id}, 32'd0);
    chk("r_msg", {21'd0, message_length, message_priority}, 32'd0);
    message_next_data = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("r_tie_grant", 32'(grant_id), 32'd0);
    chk("r_tie_new", 32'(message_new), 32'd1);
    chk("r_tie_len", 32'(message_length), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/j1708_tx_scheduler.md
# j1708_tx_scheduler

Shares the single J1708 transmit state machine between four message sources (host mailboxes), selecting one pending message per transmission by J1708 priority with round-robin tie-break. Presents the winner's length/priority to the TX state machine, routes that state machine's FIFO read strobes and empty status to the winner's data FIFO, and reports completion per source. Sits between the host-side per-source TX FIFOs and the J1708 TX state machine; optionally enforces a per-message watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 1200000: watchdog limit in clk cycles from grant to `message_done` (50 ms at 24 MHz); used only with `J1708_SCHED_TIMEOUT_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `enable`  in  1  block enable; low = return to IDLE.
- `req_valid`  in  4  per-source message pending (level).
- `req_length`  in  32  per-source byte count, `[8i+7:8i]`, including MID and checksum.
- `req_priority`  in  12  per-source J1708 priority, `[3i+2:3i]`; lower value = more urgent.
- `req_fifo_empty`  in  4  per-source data FIFO empty.
- `req_ack`  out  4  one-cycle pulse: length accepted by the TX state machine.
- `req_next_data`  out  4  routed FIFO read strobe.
- `req_done`  out  4  one-cycle pulse: message fully sent.
- `req_abort`  out  4  one-cycle pulse: watchdog expired.
- `message_length`  out  8  to TX state machine.
- `message_priority`  out  3  to TX state machine.
- `message_new`  out  1  to TX state machine.
- `message_length_read`  in  1  from TX state machine.
- `fifo_data_empty`  out  1  to TX state machine.
- `message_next_data`  in  1  from TX state machine.
- `message_done`  in  1  from TX state machine.
- `tx_enable`  out  1  enable for the TX state machine.
- `busy`  out  1  grant held.
- `grant_id`  out  2  index of current or last winner.

## Operation
- States: IDLE, ARB, OFFER, XFER, DONE, ABORT.
  - IDLE → ARB: `enable` and any `req_valid`.
  - ARB: registers the winner's index, length and priority → OFFER.
  - OFFER: `message_new`=1 until `message_length_read`, then → XFER.
  - XFER: → DONE on `message_done`.
  - DONE: `req_done[grant_id]`=1; round-robin pointer ← `grant_id`+1 (mod 4) → IDLE.
  - ABORT: → IDLE.
- Arbitration: only sources with `req_valid` compete; the minimum `req_priority` wins. Ties are resolved by searching indices starting at the round-robin pointer, ascending with wrap.
- Length and priority are latched in ARB. Changes on `req_*` after ARB are ignored until the next ARB. `req_valid` dropping after ARB does not cancel the grant.
- `req_ack[grant_id]` = `message_length_read` while in OFFER.
- Routing:
  - `req_next_data[grant_id]` = `message_next_data` in OFFER/XFER; other bits 0.
  - `fifo_data_empty` = `req_fifo_empty[grant_id]` in OFFER/XFER; otherwise 1.
- `message_done` outside XFER is ignored.
- `enable` low: next edge → IDLE. No `req_done` or `req_abort` pulse. Round-robin pointer and `grant_id` are kept. `tx_enable` = 0.
- Reset values: all outputs 0 except `fifo_data_empty`=1; round-robin pointer 0; state IDLE.

## Timing
- `req_valid` sampled high in IDLE at edge k → ARB at k+1 → `message_new`=1 from k+2. Request-to-offer latency is 2 cycles.
- `message_new`, `busy` and `tx_enable` decode from registered state. `req_next_data`, `req_ack` and `fifo_data_empty` are combinational paths from the TX state machine / FIFOs.
- `message_done` at edge m → `req_done` high during cycle m+1 → IDLE at m+2. The earliest next `message_new` is m+4.
- `busy` = 1 in ARB, OFFER, XFER, DONE and ABORT.
- `message_length_read` and `message_done` in the same cycle while in OFFER: take OFFER → XFER; the done is lost. The TX state machine cannot produce this.

## Configuration
- `J1708_SCHED_TIMEOUT_EN` defined:
  - A counter clears in ARB and increments in OFFER/XFER.
  - When it reaches `TIMEOUT_CYCLES`−1 without `message_done`, go → ABORT: `req_abort[grant_id]`=1 and `tx_enable`=0 for that one cycle, which resets the TX state machine.
  - Round-robin pointer advances as in DONE.
  - `message_done` and expiry in the same cycle: done wins.
- Not defined: no counter, no ABORT state, `req_abort`=0, `tx_enable`=`enable`.

## Test plan
- Source 2 only, length 5, priority 3, FIFO holding 5 bytes → `message_new` 2 cycles later with length 5, priority 3; 5 strobes appear on `req_next_data[2]` only; `req_done`=4'b0100 one cycle after `message_done`.
- Sources 0 (priority 6) and 3 (priority 1) valid together → `grant_id`=3; source 0 is served next.
- Sources 0, 1, 2 all priority 4, continuously valid → grant order 0, 1, 2, 0.
- `enable` dropped during XFER → IDLE next cycle; `tx_enable`=0; no `req_done`; `fifo_data_empty`=1.
- With the macro and `TIMEOUT_CYCLES`=100, no `message_done` → `req_abort` pulses 100 cycles after ARB; `tx_enable` low 1 cycle; the next valid source is granted.
- `rst_n` asserted mid-XFER → all outputs 0 immediately (`fifo_data_empty`=1); after release, source 0 wins a priority tie.
